// File: rtl/if_fetch_pc_if.sv
// Instruction-ROM fetch bus: single request/ready handshake with no outstanding requests.
interface if_fetch_pc_if;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_ready;
    logic [31:0] rom_rdata;

    modport master (output rom_en, output rom_addr, input rom_ready, input rom_rdata);
    modport slave  (input rom_en, input rom_addr, output rom_ready, output rom_rdata);
endinterface

// File: rtl/if_fetch_pc.sv
// IF-stage PC sequencer: fetches from instruction ROM, holds one instruction for ID,
// and applies branch (with delay slot), stall and exception-flush redirects.
module if_fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:0]          exc_pc,
    input  logic                 branch_valid,
    input  logic                 branch_flag,
    input  logic [31:0]          branch_addr,
    if_fetch_pc_if.master        rom,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_inst
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend_v, pend_v_nxt;
    logic [31:0] pend_addr, pend_addr_nxt;
    logic        if_valid_nxt;
    logic [31:0] if_pc_nxt, if_inst_nxt;

    logic accept;
    logic xfer;
    logic taken;

    assign accept       = !if_valid || !stall;
    assign rom.rom_en   = (state == FETCH) && accept && !flush;
    assign rom.rom_addr = pc;
    assign xfer         = rom.rom_en && rom.rom_ready;
    assign taken        = branch_valid && branch_flag;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
            if_valid  <= 1'b0;
            if_pc     <= 32'h0;
            if_inst   <= 32'h0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pend_v    <= pend_v_nxt;
            pend_addr <= pend_addr_nxt;
            if_valid  <= if_valid_nxt;
            if_pc     <= if_pc_nxt;
            if_inst   <= if_inst_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_nxt     = FETCH;
        pc_nxt        = pc;
        pend_v_nxt    = pend_v;
        pend_addr_nxt = pend_addr;
        if_valid_nxt  = if_valid;
        if_pc_nxt     = if_pc;
        if_inst_nxt   = if_inst;

        if (flush) begin
            if_valid_nxt = 1'b0;
            pend_v_nxt   = 1'b0;
            pc_nxt       = exc_pc;
        end else begin
            if (xfer) begin
                if_valid_nxt = 1'b1;
                if_pc_nxt    = pc;
                if_inst_nxt  = rom.rom_rdata;
                if (pend_v) begin
                    pc_nxt     = pend_addr;
                    pend_v_nxt = 1'b0;
                end else begin
                    pc_nxt = pc + 32'd4;
                end
            end else if (!stall && if_valid) begin
                if_valid_nxt = 1'b0;
            end

            // Held instr is the delay slot: anything fetched behind it is wrong-path.
            if (taken) begin
                if (if_valid) begin
                    if_valid_nxt = 1'b0;
                    pc_nxt       = branch_addr;
                end else if (xfer) begin
                    pc_nxt = branch_addr;
                end else begin
                    pend_v_nxt    = 1'b1;
                    pend_addr_nxt = branch_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_pc.sv
// Directed self-checking bench for if_fetch_pc: reset, delay-slot branch cases,
// stall, flush over a pending branch, PC wrap and flush during IDLE.
module tb_if_fetch_pc;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] exc_pc;
    logic        branch_valid;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        rom_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    if_fetch_pc_if rom_bus ();

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rom_bus.rom_ready = rom_ready;
    assign rom_bus.rom_rdata = rom_word(rom_bus.rom_addr);

    if_fetch_pc #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .exc_pc       (exc_pc),
        .branch_valid (branch_valid),
        .branch_flag  (branch_flag),
        .branch_addr  (branch_addr),
        .rom          (rom_bus),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle flush to addr; returns with the fetch at addr being presented.
    task automatic redirect(input logic [31:0] addr);
        flush  = 1'b1;
        exc_pc = addr;
        #1;
        check("flush_rom_en", 32'(rom_bus.rom_en), 32'd0);
        step();
        flush = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; exc_pc = 32'h0;
        branch_valid = 1'b0; branch_flag = 1'b0; branch_addr = 32'h0;
        rom_ready = 1'b1;

        // 1. Reset and sequential fetch
        repeat (3) step();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc",    if_pc,         32'h0);
        check("rst_if_inst",  if_inst,       32'h0);
        rst_n = 1'b1;
        #1;
        check("idle_rom_en",  32'(rom_bus.rom_en), 32'd0);
        step();
        check("f0_rom_en",    32'(rom_bus.rom_en), 32'd1);
        check("f0_rom_addr",  rom_bus.rom_addr,    32'hBFC0_0000);
        step();
        check("f1_if_valid",  32'(if_valid),       32'd1);
        check("f1_if_pc",     if_pc,               32'hBFC0_0000);
        check("f1_if_inst",   if_inst,             rom_word(32'hBFC0_0000));
        check("f1_rom_addr",  rom_bus.rom_addr,    32'hBFC0_0004);
        step();
        check("f2_if_pc",     if_pc,               32'hBFC0_0004);
        check("f2_rom_addr",  rom_bus.rom_addr,    32'hBFC0_0008);

        // 4. Stall holds the IF/ID register and suppresses fetch
        redirect(32'h40);
        step();
        check("st_if_pc",     if_pc,               32'h40);
        check("st_rom_addr",  rom_bus.rom_addr,    32'h44);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_rom_en",  32'(rom_bus.rom_en), 32'd0);
            check("st_hold_pc", if_pc,               32'h40);
            check("st_hold_in", if_inst,             rom_word(32'h40));
            step();
        end
        stall = 1'b0;
        #1;
        check("st_rel_en",    32'(rom_bus.rom_en), 32'd1);
        check("st_rel_addr",  rom_bus.rom_addr,    32'h44);
        step();
        check("st_next_pc",   if_pc,               32'h44);

        // 2. Case A: held instr is the delay slot, concurrent fetch discarded
        redirect(32'h104);
        step();
        check("a_if_pc",      if_pc,               32'h104);
        check("a_rom_addr",   rom_bus.rom_addr,    32'h108);
        branch_valid = 1'b1; branch_flag = 1'b1; branch_addr = 32'h200;
        step();
        branch_valid = 1'b0; branch_flag = 1'b0;
        #1;
        check("a_drop_valid", 32'(if_valid),       32'd0);
        check("a_tgt_addr",   rom_bus.rom_addr,    32'h200);
        step();
        check("a_id_valid",   32'(if_valid),       32'd1);
        check("a_id_pc",      if_pc,               32'h200);

        // 3. Case B: pending delay-slot request, branch remembered
        redirect(32'h104);
        rom_ready = 1'b0;
        branch_valid = 1'b1; branch_flag = 1'b1; branch_addr = 32'h200;
        step();
        branch_valid = 1'b0; branch_flag = 1'b0;
        check("b_wait_valid", 32'(if_valid),       32'd0);
        check("b_wait_addr",  rom_bus.rom_addr,    32'h104);
        step();
        rom_ready = 1'b1;
        #1;
        check("b_slot_en",    32'(rom_bus.rom_en), 32'd1);
        check("b_slot_addr",  rom_bus.rom_addr,    32'h104);
        step();
        check("b_slot_pc",    if_pc,               32'h104);
        check("b_tgt_addr",   rom_bus.rom_addr,    32'h200);
        step();
        check("b_tgt_pc",     if_pc,               32'h200);

        // 5. Flush overrides a pending branch
        redirect(32'h104);
        rom_ready = 1'b0;
        branch_valid = 1'b1; branch_flag = 1'b1; branch_addr = 32'h200;
        step();
        branch_valid = 1'b0; branch_flag = 1'b0;
        redirect(32'hBFC0_0380);
        rom_ready = 1'b1;
        #1;
        check("fl_if_valid",  32'(if_valid),       32'd0);
        check("fl_rom_addr",  rom_bus.rom_addr,    32'hBFC0_0380);
        step();
        check("fl_if_pc",     if_pc,               32'hBFC0_0380);
        check("fl_no_pend",   rom_bus.rom_addr,    32'hBFC0_0384);

        // 6. PC wrap, drain without transfer, flush during IDLE
        redirect(32'hFFFF_FFFC);
        check("wr_rom_addr",  rom_bus.rom_addr,    32'hFFFF_FFFC);
        step();
        check("wr_if_pc",     if_pc,               32'hFFFF_FFFC);
        check("wr_next_addr", rom_bus.rom_addr,    32'h0);
        rom_ready = 1'b0;
        step();
        check("dr_if_valid",  32'(if_valid),       32'd0);
        check("dr_rom_addr",  rom_bus.rom_addr,    32'h0);
        rom_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        flush  = 1'b1;
        exc_pc = 32'h1000;
        step();
        flush = 1'b0;
        #1;
        check("if_rom_en",    32'(rom_bus.rom_en), 32'd1);
        check("if_rom_addr",  rom_bus.rom_addr,    32'h1000);
        step();
        check("if_first_pc",  if_pc,               32'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
